// File: rtl/vram_writer_if.sv
// rtl/vram_writer_if.sv - pixel stream, control and VRAM write bus of vram_writer
//
// Purpose: groups every non-clock, non-reset signal of vram_writer.
// Ports (as seen by the writer, modport slave):
//   BLANK       in   display is not reading VRAM, writes allowed
//   START/FILL  in   pulses that begin a stream load / solid fill
//   FILL_COLOR  in   fill colour, latched when FILL is accepted
//   ABORT       in   cancel the running operation
//   PIX_*       in   pixel stream (DATA/VALID/SOF), PIX_READY out
//   WR_*        out  registered VRAM write port (ADDR/DATA/EN)
//   BUSY/DONE   out  operation in progress / one-cycle completion
//   SYNC_ERR    out  sticky stream-misalignment flag
interface vram_writer_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          BLANK;
    logic          START;
    logic          FILL;
    logic [DW-1:0] FILL_COLOR;
    logic          ABORT;
    logic [DW-1:0] PIX_DATA;
    logic          PIX_VALID;
    logic          PIX_SOF;
    logic          PIX_READY;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          WR_EN;
    logic          BUSY;
    logic          DONE;
    logic          SYNC_ERR;

    modport master (
        output BLANK, START, FILL, FILL_COLOR, ABORT, PIX_DATA, PIX_VALID, PIX_SOF,
        input  PIX_READY, WR_ADDR, WR_DATA, WR_EN, BUSY, DONE, SYNC_ERR
    );

    modport slave (
        input  BLANK, START, FILL, FILL_COLOR, ABORT, PIX_DATA, PIX_VALID, PIX_SOF,
        output PIX_READY, WR_ADDR, WR_DATA, WR_EN, BUSY, DONE, SYNC_ERR
    );
endinterface

// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - loads a pixel stream or a solid colour into VRAM during blanking
//
// Purpose: writes one full image (DEPTH words) into VRAM, either from a
// valid/ready pixel stream (LOAD) or as a single latched colour (FILL).
// Writes only happen while BLANK is high and appear one cycle after the
// pixel is accepted.
// Ports:
//   CLK    in  single clock, all logic on posedge
//   RST_N  in  asynchronous active-low reset
//   bus    vram_writer_if.slave: stream, control and VRAM write port
module vram_writer #(
    parameter int IMG_W = 150,
    parameter int IMG_H = 150,
    parameter int DEPTH = IMG_W * IMG_H,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic         CLK,
    input  logic         RST_N,
    vram_writer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [DW-1:0] color_q, color_d;
    logic          wr_en_q, wr_en_d;
    logic          done_q, done_d;
    logic          sync_err_q, sync_err_d;

    logic          do_write;
    logic [AW-1:0] addr_now;
    logic [DW-1:0] data_now;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            color_q    <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            color_q    <= color_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        color_d    = color_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        sync_err_d = sync_err_q;
        do_write   = 1'b0;
        addr_now   = cnt_q;
        data_now   = color_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d    = S_LOAD;
                    cnt_d      = '0;
                    sync_err_d = 1'b0;
                end else if (bus.FILL) begin
                    state_d    = S_FILL;
                    cnt_d      = '0;
                    sync_err_d = 1'b0;
                    color_d    = bus.FILL_COLOR;
                end
            end
            S_LOAD: begin
                // A pixel handed over in the abort cycle is dropped so that
                // nothing is written after the abort takes effect.
                if (!bus.ABORT && bus.PIX_VALID && bus.BLANK) begin
                    do_write = 1'b1;
                    data_now = bus.PIX_DATA;
                    // Mid-frame SOF: realign so this pixel lands at address 0.
                    if (bus.PIX_SOF && (cnt_q != '0)) begin
                        addr_now   = '0;
                        sync_err_d = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (!bus.ABORT && bus.BLANK) begin
                    do_write = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q != S_IDLE) && bus.ABORT) begin
            state_d = S_IDLE;
        end

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_now;
            wr_data_d = data_now;
            if (addr_now == LAST_ADDR) begin
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = addr_now + AW'(1);
            end
        end
    end

    assign bus.PIX_READY = (state_q == S_LOAD) && bus.BLANK;
    assign bus.WR_ADDR   = wr_addr_q;
    assign bus.WR_DATA   = wr_data_q;
    assign bus.WR_EN     = wr_en_q;
    assign bus.BUSY      = (state_q != S_IDLE);
    assign bus.DONE      = done_q;
    assign bus.SYNC_ERR  = sync_err_q;
endmodule

// File: tb/tb_vram_writer.sv
// tb/tb_vram_writer.sv - self-checking bench for vram_writer
module tb_vram_writer;
    localparam int W = 16;
    localparam int H = 12;
    localparam int D = W * H;
    localparam int A = 8;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [11:0]  data;
    } wr_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    vram_writer_if #(.AW(A), .DW(12)) bus ();

    vram_writer #(.IMG_W(W), .IMG_H(H), .DEPTH(D), .AW(A), .DW(12)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int  checks = 0;
    int  errors = 0;
    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_cnt;
    bit  done_wo_wr;
    bit  addr_oob;
    bit  ready_bad;
    bit  exp_sync;
    int  exp_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and record what the writer put on the VRAM port.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus.WR_EN === 1'b1) begin
            got_q.push_back({bus.WR_ADDR, bus.WR_DATA});
            if (int'(bus.WR_ADDR) >= D) addr_oob = 1'b1;
        end
        if (bus.DONE === 1'b1) begin
            done_cnt++;
            if (bus.WR_EN !== 1'b1) done_wo_wr = 1'b1;
        end
    endtask

    task automatic idle_inputs();
        bus.START      = 1'b0;
        bus.FILL       = 1'b0;
        bus.ABORT      = 1'b0;
        bus.PIX_VALID  = 1'b0;
        bus.PIX_SOF    = 1'b0;
        bus.PIX_DATA   = '0;
        bus.FILL_COLOR = '0;
        bus.BLANK      = 1'b1;
    endtask

    task automatic clear_log();
        got_q.delete();
        exp_q.delete();
        done_cnt   = 0;
        done_wo_wr = 1'b0;
        addr_oob   = 1'b0;
        ready_bad  = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, " wr_en"},     bus.WR_EN, 0);
        chk({tag, " wr_addr"},   bus.WR_ADDR, 0);
        chk({tag, " wr_data"},   bus.WR_DATA, 0);
        chk({tag, " pix_ready"}, bus.PIX_READY, 0);
        chk({tag, " busy"},      bus.BUSY, 0);
        chk({tag, " done"},      bus.DONE, 0);
        chk({tag, " sync_err"},  bus.SYNC_ERR, 0);
    endtask

    task automatic check_log(input string tag);
        int bad = 0;
        chk({tag, " writes"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i >= got_q.size()) bad++;
            else if (got_q[i] !== exp_q[i]) bad++;
        end
        chk({tag, " content"},      bad, 0);
        chk({tag, " done_with_wr"}, done_wo_wr, 0);
        chk({tag, " addr_range"},   addr_oob, 0);
        chk({tag, " ready"},        ready_bad, 0);
        chk({tag, " done_count"},   done_cnt, exp_done);
    endtask

    // Stream load. The model: a frame is the list of accepted pixels since the
    // most recent SOF; the k-th pixel of a frame belongs at VRAM address k, and
    // the image is complete once a frame reaches D pixels.
    task automatic run_load(input string tag, input int sof_at, input int abort_at, input bit rnd);
        int          pos  = 0;
        int          sent = 0;
        int          cyc  = 0;
        bit          fin  = 1'b0;
        bit          blank, valid, sof;
        logic [11:0] pix;
        clear_log();
        exp_sync = 1'b0;
        exp_done = 0;
        pix = 12'($urandom);
        bus.BLANK = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        chk({tag, " busy"},     bus.BUSY, 1);
        chk({tag, " sync_clr"}, bus.SYNC_ERR, 0);
        while (!fin && cyc < 20000) begin
            blank = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            sof   = (sent == 0) || (sent == sof_at);
            bus.BLANK     = blank;
            bus.PIX_VALID = valid;
            bus.PIX_DATA  = pix;
            bus.PIX_SOF   = sof;
            bus.ABORT     = (pos == abort_at);
            #1;
            if (bus.PIX_READY !== blank) ready_bad = 1'b1;
            if (pos == abort_at) begin
                fin = 1'b1;
            end else if (blank && valid) begin
                if (sof && pos != 0) begin
                    exp_sync = 1'b1;
                    pos = 0;
                end
                exp_q.push_back({A'(pos), pix});
                pos++;
                sent++;
                pix = 12'($urandom);
                if (pos == D) begin
                    fin = 1'b1;
                    exp_done = 1;
                end
            end
            tick();
            cyc++;
        end
        idle_inputs();
        chk({tag, " finished"}, fin, 1);
        tick();
        tick();
        check_log(tag);
        chk({tag, " busy_after"}, bus.BUSY, 0);
        chk({tag, " sync_err"},   bus.SYNC_ERR, exp_sync);
    endtask

    // Solid fill: every BLANK-high cycle writes the colour latched at FILL to
    // the next address. A START and a FILL with another colour are thrown at
    // it mid-operation and must change nothing.
    task automatic run_fill(input string tag, input logic [11:0] color, input bit toggle, input int reset_at);
        int pos = 0;
        int cyc = 0;
        bit fin = 1'b0;
        bit blank;
        clear_log();
        exp_done = 0;
        bus.BLANK      = 1'b1;
        bus.FILL_COLOR = color;
        bus.FILL       = 1'b1;
        tick();
        bus.FILL       = 1'b0;
        bus.FILL_COLOR = ~color;
        chk({tag, " busy"}, bus.BUSY, 1);
        while (!fin && cyc < 20000) begin
            blank = toggle ? (((cyc / 50) % 2) == 0) : 1'($urandom_range(0, 1));
            bus.BLANK = blank;
            bus.START = (cyc == 7);
            bus.FILL  = (cyc == 9);
            if (pos == reset_at) begin
                RST_N = 1'b0;
                #1;
                reset_vals({tag, " async_rst"});
                fin = 1'b1;
            end else begin
                #1;
                if (bus.PIX_READY !== 1'b0) ready_bad = 1'b1;
                if (blank) begin
                    exp_q.push_back({A'(pos), color});
                    pos++;
                    if (pos == D) begin
                        fin = 1'b1;
                        exp_done = 1;
                    end
                end
            end
            tick();
            cyc++;
        end
        idle_inputs();
        chk({tag, " finished"}, fin, 1);
        if (reset_at >= 0) begin
            repeat (3) tick();
            RST_N = 1'b1;
            repeat (20) tick();
        end else begin
            tick();
            tick();
        end
        check_log(tag);
        chk({tag, " busy_after"}, bus.BUSY, 0);
    endtask

    initial begin
        idle_inputs();
        clear_log();
        RST_N = 1'b0;
        repeat (3) tick();
        reset_vals("reset");
        RST_N = 1'b1;
        tick();
        chk("idle busy", bus.BUSY, 0);

        run_load("load_full", -1, -1, 1'b0);
        run_load("load_rand", -1, -1, 1'b1);
        run_load("load_sof", 99, -1, 1'b1);
        run_load("load_abort", -1, 50, 1'b1);
        run_load("load_after_abort", -1, -1, 1'b0);

        // START and FILL together: LOAD wins, so the stream port opens.
        clear_log();
        idle_inputs();
        bus.START      = 1'b1;
        bus.FILL       = 1'b1;
        bus.FILL_COLOR = 12'h0AB;
        tick();
        bus.START = 1'b0;
        bus.FILL  = 1'b0;
        #1;
        chk("both pix_ready", bus.PIX_READY, 1);
        chk("both busy", bus.BUSY, 1);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        tick();
        chk("both busy_after_abort", bus.BUSY, 0);
        chk("both no_writes", got_q.size(), 0);

        run_fill("fill_toggle", 12'hF00, 1'b1, -1);
        run_fill("fill_reset", 12'($urandom), 1'b0, 100);
        run_fill("fill_rand", 12'($urandom), 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
